// File: rtl/lab_pkg.sv
// Shared definitions for the audio frame sequencer.
//   DATA_W      default sample width (signed two's complement)
//   FX_TIMEOUT  default FX watchdog limit in clk cycles
//   CNT_W       default width of the frame and timeout counters
//   seq_state_t sequencer state: capture, FX processing, DAC playback
package lab_pkg;

    localparam int DATA_W     = 16;
    localparam int FX_TIMEOUT = 1024;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        SEQ_CAPTURE  = 2'd0,
        SEQ_PROCESS  = 2'd1,
        SEQ_PLAYBACK = 2'd2
    } seq_state_t;

endpackage

// File: rtl/audio_chan_slot.sv
// One audio channel slot: a sample register plus a single handshake flag.
// Capture slots use the flag as "ready" (reset to 1), playback slots use it
// as "valid" (reset to 0).
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   load, d        write d into the sample register
//   set, clr       raise / lower the flag (clr wins if both are high)
//   q              held sample
//   flag           handshake flag (ready or valid, depending on use)
module audio_chan_slot
    import lab_pkg::*;
#(
    parameter int W          = DATA_W,
    parameter bit FLAG_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         set,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         flag
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q    <= '0;
            flag <= FLAG_RESET;
        end else begin
            if (load) begin
                q <= d;
            end
            if (clr) begin
                flag <= 1'b0;
            end else if (set) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_frame_sequencer.sv
// Stereo frame sequencer between codec ADC sources, an FX chain and DAC sinks.
// Each frame: capture one L/R pair, pulse fx_start, wait for fx_done, then
// hand the processed pair to the DAC. Mute is latched when the frame's second
// sample is captured and applies to that frame's output only.
// Optional feature macro: AUDIO_SEQ_WATCHDOG_EN -- when defined, a PROCESS
// watchdog bypasses the FX result with the dry samples after FX_TIMEOUT cycles
// and counts expiries in timeout_count; otherwise PROCESS waits indefinitely
// and timeout_count is tied to 0.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   adc_data/valid/ready    ADC streams, index 0 = left, 1 = right
//   dac_data/valid/ready    DAC streams, index 0 = left, 1 = right
//   mute                    zero the outputs of the frame it is latched in
//   fx_start, fx_in_l/r     FX launch pulse and captured samples
//   fx_done, fx_out_l/r     FX result strobe and processed samples
//   busy                    high in PROCESS or PLAYBACK
//   frame_count             completed frames (wrapping)
//   timeout_count           watchdog expiries (saturating)
//   dbg_state               current sequencer state
//
// Handshake: a sample transfers on a clk edge where valid and ready are both
// high. Our valid (dac_valid) and ready (adc_ready) are registered and never
// depend combinationally on the partner's ready/valid; once dac_valid[c] rises
// it stays high with dac_data[c] stable until the transfer occurs.
module audio_frame_sequencer #(
    parameter int DATA_W     = lab_pkg::DATA_W,
    parameter int FX_TIMEOUT = lab_pkg::FX_TIMEOUT,
    parameter int CNT_W      = lab_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0][DATA_W-1:0] adc_data,
    input  logic [1:0]             adc_valid,
    output logic [1:0]             adc_ready,
    output logic [1:0][DATA_W-1:0] dac_data,
    output logic [1:0]             dac_valid,
    input  logic [1:0]             dac_ready,
    input  logic                   mute,
    output logic                   fx_start,
    output logic [DATA_W-1:0]      fx_in_l,
    output logic [DATA_W-1:0]      fx_in_r,
    input  logic                   fx_done,
    input  logic [DATA_W-1:0]      fx_out_l,
    input  logic [DATA_W-1:0]      fx_out_r,
    output logic                   busy,
    output logic [CNT_W-1:0]       frame_count,
    output logic [CNT_W-1:0]       timeout_count,
    output lab_pkg::seq_state_t    dbg_state
);

    import lab_pkg::*;

    if (FX_TIMEOUT < 1) begin : g_bad_timeout
        $error("FX_TIMEOUT must be at least 1");
    end

    seq_state_t             state;
    logic                   mute_f;
    logic [1:0]             cap_ready;
    logic [1:0]             pb_valid;
    logic [1:0][DATA_W-1:0] cap_q;
    logic [1:0][DATA_W-1:0] pb_q;
    logic [1:0][DATA_W-1:0] pb_d;
    logic [1:0]             cap_hs;
    logic [1:0]             pb_hs;
    logic                   capture_done;
    logic                   playback_done;
    logic                   fx_accept;
    logic                   wd_expire;
    logic                   pb_load;

`ifdef AUDIO_SEQ_WATCHDOG_EN
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    always_comb begin
        cap_hs = adc_valid & cap_ready;
        pb_hs  = dac_ready & pb_valid;
        // A channel counts as captured if it already is, or transfers now.
        capture_done  = (state == SEQ_CAPTURE) && ((~cap_ready | adc_valid) == 2'b11);
        playback_done = (state == SEQ_PLAYBACK) && ((~pb_valid | dac_ready) == 2'b11);
        fx_accept     = (state == SEQ_PROCESS) && fx_done;
`ifdef AUDIO_SEQ_WATCHDOG_EN
        // fx_done in the expiry cycle takes priority over the dry bypass.
        wd_expire = (state == SEQ_PROCESS) && !fx_done &&
                    (wd_cnt == CNT_W'(FX_TIMEOUT - 1));
`else
        wd_expire = 1'b0;
`endif
        pb_load = fx_accept | wd_expire;
        if (mute_f) begin
            pb_d = '0;
        end else if (fx_accept) begin
            pb_d = {fx_out_r, fx_out_l};
        end else begin
            pb_d = cap_q;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_chan
        // Capture flag is adc_ready: drops on transfer, re-arms at frame end.
        audio_chan_slot #(.W(DATA_W), .FLAG_RESET(1'b1)) u_cap (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (cap_hs[c]),
            .d       (adc_data[c]),
            .set     (playback_done),
            .clr     (cap_hs[c]),
            .q       (cap_q[c]),
            .flag    (cap_ready[c])
        );

        // Playback flag is dac_valid: raised with the result, drops on transfer.
        audio_chan_slot #(.W(DATA_W), .FLAG_RESET(1'b0)) u_pb (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (pb_load),
            .d       (pb_d[c]),
            .set     (pb_load),
            .clr     (pb_hs[c]),
            .q       (pb_q[c]),
            .flag    (pb_valid[c])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= SEQ_CAPTURE;
            fx_start    <= 1'b0;
            busy        <= 1'b0;
            mute_f      <= 1'b0;
            frame_count <= '0;
        end else begin
            fx_start <= 1'b0;
            case (state)
                SEQ_CAPTURE: begin
                    if (capture_done) begin
                        state    <= SEQ_PROCESS;
                        fx_start <= 1'b1;
                        busy     <= 1'b1;
                        mute_f   <= mute;
                    end
                end
                SEQ_PROCESS: begin
                    if (pb_load) begin
                        state <= SEQ_PLAYBACK;
                    end
                end
                SEQ_PLAYBACK: begin
                    if (playback_done) begin
                        state       <= SEQ_CAPTURE;
                        busy        <= 1'b0;
                        frame_count <= frame_count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= SEQ_CAPTURE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUDIO_SEQ_WATCHDOG_EN
    // wd_cnt is 0 in the fx_start cycle and counts each PROCESS cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state != SEQ_PROCESS) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (wd_expire && (tmo_cnt != '1)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
        end
    end

    assign timeout_count = tmo_cnt;
`else
    assign timeout_count = '0;
`endif

    assign adc_ready = cap_ready;
    assign dac_valid = pb_valid;
    assign dac_data  = pb_q;
    assign fx_in_l   = cap_q[0];
    assign fx_in_r   = cap_q[1];
    assign dbg_state = state;

endmodule
